// File: rtl/writeback_unit_pkg.sv
// Shared constants for the MIPS write-back stage: widths, load-type encodings
// and the architectural register numbers the stage treats specially.
package writeback_unit_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   typedef enum logic [2:0] {
      LD_LW  = 3'd0,
      LD_LB  = 3'd1,
      LD_LBU = 3'd2,
      LD_LH  = 3'd3,
      LD_LHU = 3'd4
   } load_type_e;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/Mux2_1_32.sv
// Two-input, datapath-wide select; sel=1 picks in1.
module Mux2_1_32
   import writeback_unit_pkg::*;
(
   input  logic              sel,
   input  logic [DATA_W-1:0] in0,
   input  logic [DATA_W-1:0] in1,
   output logic [DATA_W-1:0] out
);

   assign out = sel ? in1 : in0;

endmodule

// File: rtl/writeback_unit.sv
// MIPS write-back stage: MEM/WB register, load extract/extend, result select,
// register-file write port / forwarding source and retired-instruction counter.
module writeback_unit #(
   parameter int DATA_W = writeback_unit_pkg::DATA_W,
   parameter int ADDR_W = writeback_unit_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_valid,
   input  logic              stall,
   input  logic              flush,
   input  logic [DATA_W-1:0] mem_alu_result,
   input  logic [DATA_W-1:0] mem_rd_data,
   input  logic [DATA_W-1:0] mem_pc_plus4,
   input  logic [ADDR_W-1:0] mem_reg_wr_addr,
   input  logic              mem_reg_write,
   input  logic              mem_to_reg,
   input  logic              mem_link,
   input  logic [2:0]        mem_load_type,
   output logic              reg_write,
   output logic [ADDR_W-1:0] reg_wr_addr,
   output logic [DATA_W-1:0] reg_wr_data,
   output logic              wb_fwd_valid,
   output logic              wb_align_err,
   output logic              wb_align_err_sticky,
   output logic [31:0]       wb_retire_count
);

   import writeback_unit_pkg::LD_LB;
   import writeback_unit_pkg::LD_LBU;
   import writeback_unit_pkg::LD_LH;
   import writeback_unit_pkg::LD_LHU;
   import writeback_unit_pkg::REG_ZERO;
   import writeback_unit_pkg::REG_RA;

   logic              wb_valid;
   logic              wb_fresh;
   logic [DATA_W-1:0] wb_alu_result;
   logic [DATA_W-1:0] wb_rd_data;
   logic [DATA_W-1:0] wb_pc_plus4;
   logic [ADDR_W-1:0] wb_addr;
   logic              wb_reg_write;
   logic              wb_mem_to_reg;
   logic              wb_link;
   logic [2:0]        wb_load_type;
   logic              sticky_q;
   logic [31:0]       retire_q;

   logic [1:0]        lane;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [DATA_W-1:0] load_ext;
   logic              misaligned;
   logic [DATA_W-1:0] sel_data;
   logic              first_cycle;

   // Pipeline control: stall=0 captures the MEM stage every edge (fresh=1);
   // stall=1 holds every field and drops fresh so a held instruction writes
   // once; flush forces valid=0 regardless of stall.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_valid      <= 1'b0;
         wb_fresh      <= 1'b0;
         wb_alu_result <= '0;
         wb_rd_data    <= '0;
         wb_pc_plus4   <= '0;
         wb_addr       <= '0;
         wb_reg_write  <= 1'b0;
         wb_mem_to_reg <= 1'b0;
         wb_link       <= 1'b0;
         wb_load_type  <= 3'd0;
         sticky_q      <= 1'b0;
         retire_q      <= 32'd0;
      end else begin
         if (!stall) begin
            wb_valid      <= mem_valid & ~flush;
            wb_fresh      <= 1'b1;
            wb_alu_result <= mem_alu_result;
            wb_rd_data    <= mem_rd_data;
            wb_pc_plus4   <= mem_pc_plus4;
            wb_addr       <= mem_reg_wr_addr;
            wb_reg_write  <= mem_reg_write;
            wb_mem_to_reg <= mem_to_reg;
            wb_link       <= mem_link;
            wb_load_type  <= mem_load_type;
            // Counted at capture so the count already includes the
            // instruction during its single valid & fresh cycle.
            if (mem_valid && !flush) retire_q <= retire_q + 32'd1;
         end else begin
            wb_fresh <= 1'b0;
            if (flush) wb_valid <= 1'b0;
         end
         if (wb_align_err) sticky_q <= 1'b1;
      end
   end

   assign lane    = wb_alu_result[1:0];
   assign ld_byte = wb_rd_data[{lane, 3'b000} +: 8];
   assign ld_half = wb_rd_data[{lane[1], 4'b0000} +: 16];

   always_comb begin
      load_ext   = wb_rd_data;
      misaligned = 1'b0;
      case (wb_load_type)
         LD_LB:  load_ext = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
         LD_LBU: load_ext = {{(DATA_W-8){1'b0}}, ld_byte};
         LD_LH: begin
            load_ext   = {{(DATA_W-16){ld_half[15]}}, ld_half};
            misaligned = lane[0];
         end
         LD_LHU: begin
            load_ext   = {{(DATA_W-16){1'b0}}, ld_half};
            misaligned = lane[0];
         end
         default: misaligned = (lane != 2'd0);
      endcase
      misaligned = misaligned & wb_mem_to_reg;
   end

   Mux2_1_32 u_load_mux (
      .sel (wb_mem_to_reg),
      .in0 (wb_alu_result),
      .in1 (load_ext),
      .out (sel_data)
   );

   Mux2_1_32 u_link_mux (
      .sel (wb_link),
      .in0 (sel_data),
      .in1 (wb_pc_plus4),
      .out (reg_wr_data)
   );

   assign reg_wr_addr         = wb_link ? ADDR_W'(REG_RA) : wb_addr;
   assign first_cycle         = wb_valid & wb_fresh;
   assign reg_write           = first_cycle & wb_reg_write & ~misaligned &
                                (reg_wr_addr != ADDR_W'(REG_ZERO));
   assign wb_fwd_valid        = reg_write;
   assign wb_align_err        = first_cycle & misaligned;
   assign wb_align_err_sticky = sticky_q | wb_align_err;
   assign wb_retire_count     = retire_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: hand-computed vectors, expected-queue
// scoreboard for the write port, and a small retire-count model.
module tb_writeback_unit;
   import writeback_unit_pkg::*;

   localparam int W = 1 + ADDR_W + DATA_W;
   localparam logic [DATA_W-1:0] RD = 32'h80FF7F01;

   logic              clk = 1'b0;
   logic              reset;
   logic              mem_valid, stall, flush;
   logic [DATA_W-1:0] mem_alu_result, mem_rd_data, mem_pc_plus4;
   logic [ADDR_W-1:0] mem_reg_wr_addr;
   logic              mem_reg_write, mem_to_reg, mem_link;
   logic [2:0]        mem_load_type;
   logic              reg_write;
   logic [ADDR_W-1:0] reg_wr_addr;
   logic [DATA_W-1:0] reg_wr_data;
   logic              wb_fwd_valid, wb_align_err, wb_align_err_sticky;
   logic [31:0]       wb_retire_count;

   int          checks = 0;
   int          errors = 0;
   logic [W-1:0] exp_q[$];
   logic [31:0] exp_count;

   writeback_unit dut (
      .clk                 (clk),
      .reset               (reset),
      .mem_valid           (mem_valid),
      .stall               (stall),
      .flush               (flush),
      .mem_alu_result      (mem_alu_result),
      .mem_rd_data         (mem_rd_data),
      .mem_pc_plus4        (mem_pc_plus4),
      .mem_reg_wr_addr     (mem_reg_wr_addr),
      .mem_reg_write       (mem_reg_write),
      .mem_to_reg          (mem_to_reg),
      .mem_link            (mem_link),
      .mem_load_type       (mem_load_type),
      .reg_write           (reg_write),
      .reg_wr_addr         (reg_wr_addr),
      .reg_wr_data         (reg_wr_data),
      .wb_fwd_valid        (wb_fwd_valid),
      .wb_align_err        (wb_align_err),
      .wb_align_err_sticky (wb_align_err_sticky),
      .wb_retire_count     (wb_retire_count)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drivers
   task automatic set_idle();
      mem_valid = 1'b0; stall = 1'b0; flush = 1'b0;
      mem_alu_result = '0; mem_rd_data = '0; mem_pc_plus4 = '0;
      mem_reg_wr_addr = '0; mem_reg_write = 1'b0; mem_to_reg = 1'b0;
      mem_link = 1'b0; mem_load_type = 3'd0;
   endtask

   task automatic drive(input logic v, input logic [2:0] ltype, input logic to_reg,
                        input logic link, input logic rw, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] rd,
                        input logic [DATA_W-1:0] pc);
      mem_valid = v; mem_load_type = ltype; mem_to_reg = to_reg; mem_link = link;
      mem_reg_write = rw; mem_reg_wr_addr = addr; mem_alu_result = alu;
      mem_rd_data = rd; mem_pc_plus4 = pc;
   endtask

   // One clock; retire model counts every accepted, unflushed valid instruction.
   task automatic step();
      if (reset && mem_valid && !stall && !flush) exp_count = exp_count + 32'd1;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard
   task automatic expect_wb(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] data);
      exp_q.push_back({we, addr, data});
   endtask

   task automatic check_wb(input string tag);
      logic [W-1:0] e;
      if (exp_q.size() == 0) begin
         check_val({tag, ".sb_empty"}, 64'(exp_q.size()), 64'd1);
      end else begin
         e = exp_q.pop_front();
         check_val({tag, ".we"},   64'(reg_write),    64'(e[W-1]));
         check_val({tag, ".fwd"},  64'(wb_fwd_valid), 64'(e[W-1]));
         check_val({tag, ".addr"}, 64'(reg_wr_addr),  64'(e[W-2 -: ADDR_W]));
         check_val({tag, ".data"}, 64'(reg_wr_data),  64'(e[DATA_W-1:0]));
         check_val({tag, ".cnt"},  64'(wb_retire_count), 64'(exp_count));
      end
   endtask

   task automatic send(input string tag, input logic v, input logic [2:0] ltype,
                       input logic to_reg, input logic link, input logic rw,
                       input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] alu,
                       input logic [DATA_W-1:0] rd, input logic [DATA_W-1:0] pc,
                       input logic ewe, input logic [ADDR_W-1:0] eaddr,
                       input logic [DATA_W-1:0] edata);
      drive(v, ltype, to_reg, link, rw, addr, alu, rd, pc);
      expect_wb(ewe, eaddr, edata);
      step();
      check_wb(tag);
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, ".we"},     64'(reg_write),           64'd0);
      check_val({tag, ".addr"},   64'(reg_wr_addr),         64'd0);
      check_val({tag, ".data"},   64'(reg_wr_data),         64'd0);
      check_val({tag, ".fwd"},    64'(wb_fwd_valid),        64'd0);
      check_val({tag, ".err"},    64'(wb_align_err),        64'd0);
      check_val({tag, ".sticky"}, 64'(wb_align_err_sticky), 64'd0);
      check_val({tag, ".cnt"},    64'(wb_retire_count),     64'd0);
   endtask

   initial begin
      reset = 1'b0;
      exp_count = 32'd0;
      set_idle();
      #3;
      check_all_zero("rst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      // ALU result and load extraction, back to back
      send("alu",   1, LD_LW,  0, 0, 1, 5'd8,  32'h00001234, RD, 0, 1, 5'd8,  32'h00001234);
      check_val("alu.cnt1", 64'(wb_retire_count), 64'd1);
      send("lb3",   1, LD_LB,  1, 0, 1, 5'd9,  32'h00001003, RD, 0, 1, 5'd9,  32'hFFFFFF80);
      send("lbu3",  1, LD_LBU, 1, 0, 1, 5'd10, 32'h00001003, RD, 0, 1, 5'd10, 32'h00000080);
      send("lh2",   1, LD_LH,  1, 0, 1, 5'd11, 32'h00001002, RD, 0, 1, 5'd11, 32'hFFFF80FF);
      send("lhu0",  1, LD_LHU, 1, 0, 1, 5'd12, 32'h00001000, RD, 0, 1, 5'd12, 32'h00007F01);
      send("lw0",   1, LD_LW,  1, 0, 1, 5'd13, 32'h00001004, RD, 0, 1, 5'd13, 32'h80FF7F01);
      send("lb2",   1, LD_LB,  1, 0, 1, 5'd14, 32'h00001002, RD, 0, 1, 5'd14, 32'hFFFFFFFF);
      send("lb1",   1, LD_LB,  1, 0, 1, 5'd15, 32'h00001001, RD, 0, 1, 5'd15, 32'h0000007F);
      send("lhu2",  1, LD_LHU, 1, 0, 1, 5'd16, 32'h00001002, RD, 0, 1, 5'd16, 32'h000080FF);
      send("ltype7",1, 3'd7,   1, 0, 1, 5'd17, 32'h00001000, RD, 0, 1, 5'd17, 32'h80FF7F01);

      // Link override, $0 write, store, bubble
      send("link",  1, LD_LW,  0, 1, 1, 5'd5,  32'h00000077, RD, 32'h00400010, 1, 5'd31, 32'h00400010);
      send("r0",    1, LD_LW,  0, 0, 1, 5'd0,  32'h00000055, RD, 0, 0, 5'd0,  32'h00000055);
      send("store", 1, LD_LW,  0, 0, 0, 5'd6,  32'h00000099, RD, 0, 0, 5'd6,  32'h00000099);
      send("bub",   0, LD_LW,  0, 0, 1, 5'd7,  32'h000000AA, RD, 0, 0, 5'd7,  32'h000000AA);

      // Stall: one write despite three held cycles and changing inputs
      send("stl_cap", 1, LD_LW, 0, 0, 1, 5'd3, 32'h0000CAFE, RD, 0, 1, 5'd3, 32'h0000CAFE);
      stall = 1'b1;
      drive(1, LD_LW, 0, 0, 1, 5'd4, 32'h0000DEAD, RD, 0);
      for (int i = 0; i < 3; i++) begin
         expect_wb(0, 5'd3, 32'h0000CAFE);
         step();
         check_wb("stl_hold");
      end
      stall = 1'b0;
      send("stl_rel", 0, LD_LW, 0, 0, 1, 5'd4, 32'h0000DEAD, RD, 0, 0, 5'd4, 32'h0000DEAD);

      // Flush wins over stall; flush without stall inserts a bubble
      send("fl_cap", 1, LD_LW, 0, 0, 1, 5'd2, 32'h0000F00D, RD, 0, 1, 5'd2, 32'h0000F00D);
      stall = 1'b1; flush = 1'b1;
      expect_wb(0, 5'd2, 32'h0000F00D);
      step();
      check_wb("fl_stl");
      stall = 1'b0;
      send("fl_nostl", 1, LD_LW, 0, 0, 1, 5'd15, 32'h0000BEEF, RD, 0, 0, 5'd15, 32'h0000BEEF);
      flush = 1'b0;

      // Misaligned loads: suppressed write, one-cycle pulse, sticky flag
      send("mis_lh", 1, LD_LH, 1, 0, 1, 5'd7, 32'h00001001, RD, 0, 0, 5'd7, 32'h00007F01);
      check_val("mis_lh.err",    64'(wb_align_err),        64'd1);
      check_val("mis_lh.sticky", 64'(wb_align_err_sticky), 64'd1);
      send("mis_after", 1, LD_LW, 0, 0, 1, 5'd8, 32'h00000001, RD, 0, 1, 5'd8, 32'h00000001);
      check_val("mis_after.err",    64'(wb_align_err),        64'd0);
      check_val("mis_after.sticky", 64'(wb_align_err_sticky), 64'd1);
      send("mis_lw", 1, LD_LW, 1, 0, 1, 5'd9, 32'h00001002, RD, 0, 0, 5'd9, 32'h80FF7F01);
      check_val("mis_lw.err", 64'(wb_align_err), 64'd1);
      send("aln_lh", 1, LD_LH, 1, 0, 1, 5'd10, 32'h00001000, RD, 0, 1, 5'd10, 32'h00007F01);
      check_val("aln_lh.err",    64'(wb_align_err),        64'd0);
      check_val("aln_lh.sticky", 64'(wb_align_err_sticky), 64'd1);

      // Asynchronous reset in the middle of a stall discards the held instruction
      send("rs_cap", 1, LD_LW, 0, 0, 1, 5'd20, 32'h00001111, RD, 0, 1, 5'd20, 32'h00001111);
      stall = 1'b1;
      #2;
      reset = 1'b0;
      exp_count = 32'd0;
      #1;
      check_all_zero("rs_mid");
      @(negedge clk);
      reset = 1'b1;
      expect_wb(0, 5'd0, 32'h00000000);
      step();
      check_wb("rs_held");
      check_val("rs_held.sticky", 64'(wb_align_err_sticky), 64'd0);
      stall = 1'b0;
      send("rs_next", 1, LD_LW, 0, 0, 1, 5'd21, 32'h00002222, RD, 0, 1, 5'd21, 32'h00002222);
      check_val("rs_next.cnt1", 64'(wb_retire_count), 64'd1);

      set_idle();
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
